// File: rtl/rx_port_arbiter_if.sv
// Handshake bundle between the PHY FIFO status flags, the MAC decoder and the
// receive port arbiter. The arbiter connects through the slave modport.
interface rx_port_arbiter_if;
    logic [3:0] i_fifo_aempty;
    logic       h_fifo_full;
    logic       b_fifo_afull;
    logic       frame_done;
    logic       byte_strobe;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       grant_start;
    logic       abort;
    logic [7:0] abort_cnt;

    modport slave (
        input  i_fifo_aempty,
        input  h_fifo_full,
        input  b_fifo_afull,
        input  frame_done,
        input  byte_strobe,
        output grant_valid,
        output grant_id,
        output grant_start,
        output abort,
        output abort_cnt
    );

    modport master (
        output i_fifo_aempty,
        output h_fifo_full,
        output b_fifo_afull,
        output frame_done,
        output byte_strobe,
        input  grant_valid,
        input  grant_id,
        input  grant_start,
        input  abort,
        input  abort_cnt
    );
endinterface

// File: rtl/rx_port_arbiter.sv
// Frame-granular round-robin arbiter over four PHY receive FIFOs.
// Define RX_ARB_WATCHDOG_EN to build the stall watchdog (abort / abort_cnt).
module rx_port_arbiter #(
    parameter int WDT_WIDTH = 16,
    parameter int WDT_LIMIT = 3000
) (
    input  logic               clk,
    input  logic               arst_n,
    rx_port_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam bit WDT_CFG_OK = (WDT_LIMIT < (1 << WDT_WIDTH));

    state_t     state_r;
    state_t     state_s;
    logic [1:0] rr_ptr_r;
    logic [1:0] rr_ptr_s;
    logic       grant_valid_r;
    logic       grant_valid_s;
    logic [1:0] grant_id_r;
    logic [1:0] grant_id_s;
    logic       grant_start_r;
    logic       grant_start_s;
    logic       abort_r;
    logic       abort_s;
    logic [7:0] abort_cnt_r;
    logic [7:0] abort_cnt_s;

    logic [3:0] ready_s;
    logic       eligible_s;
    logic [1:0] pick_s;
    logic       expire_s;
    logic       release_s;
    logic       abort_ev_s;
    logic       unused_s;

    assign ready_s    = ~bus.i_fifo_aempty;
    assign eligible_s = (bus.h_fifo_full == 1'b0) && (bus.b_fifo_afull == 1'b0) && (ready_s != 4'b0000);

    // Rotating search: scanning offsets high to low leaves the lowest offset from rr_ptr as winner
    always_comb begin
        pick_s = rr_ptr_r;
        for (int k = 3; k >= 0; k--) begin
            if (ready_s[rr_ptr_r + 2'(k)]) begin
                pick_s = rr_ptr_r + 2'(k);
            end else begin
                pick_s = pick_s;
            end
        end
    end

`ifdef RX_ARB_WATCHDOG_EN
    logic [WDT_WIDTH-1:0] wdt_r;
    logic [WDT_WIDTH-1:0] wdt_s;

    assign expire_s = (state_r == S_HOLD) && (wdt_r == WDT_WIDTH'(WDT_LIMIT));
    assign unused_s = WDT_CFG_OK;

    // Watchdog next value: counts idle hold cycles, restarted by every consumed byte
    always_comb begin
        wdt_s = '0;
        if ((state_r == S_HOLD) && !release_s) begin
            if (bus.byte_strobe) begin
                wdt_s = '0;
            end else begin
                wdt_s = wdt_r + WDT_WIDTH'(1);
            end
        end else begin
            wdt_s = '0;
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wdt_r <= '0;
        end else begin
            wdt_r <= wdt_s;
        end
    end
`else
    assign expire_s = 1'b0;
    assign unused_s = bus.byte_strobe ^ WDT_CFG_OK;
`endif

    // frame_done has priority over a coincident expiry, so no abort in that case
    assign release_s  = (state_r == S_HOLD) && (bus.frame_done || expire_s);
    assign abort_ev_s = (state_r == S_HOLD) && !bus.frame_done && expire_s;

    // State register
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (eligible_s) begin
                    state_s = S_HOLD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_HOLD: begin
                if (release_s) begin
                    state_s = S_GAP;
                end else begin
                    state_s = S_HOLD;
                end
            end
            S_GAP:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and the rotation pointer
    always_comb begin
        grant_valid_s = (state_s == S_HOLD);
        grant_start_s = (state_r == S_IDLE) && eligible_s;
        abort_s       = abort_ev_s;
        if (grant_start_s) begin
            grant_id_s = pick_s;
        end else begin
            grant_id_s = grant_id_r;
        end
        if (release_s) begin
            rr_ptr_s = grant_id_r + 2'd1;
        end else begin
            rr_ptr_s = rr_ptr_r;
        end
        if (abort_ev_s && (abort_cnt_r != 8'hFF)) begin
            abort_cnt_s = abort_cnt_r + 8'd1;
        end else begin
            abort_cnt_s = abort_cnt_r;
        end
    end

    // Output and pointer registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            grant_valid_r <= 1'b0;
            grant_id_r    <= 2'd0;
            grant_start_r <= 1'b0;
            abort_r       <= 1'b0;
            abort_cnt_r   <= 8'd0;
            rr_ptr_r      <= 2'd0;
        end else begin
            grant_valid_r <= grant_valid_s;
            grant_id_r    <= grant_id_s;
            grant_start_r <= grant_start_s;
            abort_r       <= abort_s;
            abort_cnt_r   <= abort_cnt_s;
            rr_ptr_r      <= rr_ptr_s;
        end
    end

    assign bus.grant_valid = grant_valid_r;
    assign bus.grant_id    = grant_id_r;
    assign bus.grant_start = grant_start_r;
    assign bus.abort       = abort_r;
    assign bus.abort_cnt   = abort_cnt_r;

endmodule

// File: tb/tb_rx_port_arbiter.sv
// Self-checking bench for rx_port_arbiter against a round-robin reference model.
// Watchdog scenarios are built only when RX_ARB_WATCHDOG_EN is defined.
module tb_rx_port_arbiter;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   ref_ptr = 0;
    int   exp_abort_cnt = 0;

    always #5 clk = ~clk;

    rx_port_arbiter_if bus();

    rx_port_arbiter #(.WDT_WIDTH(16), .WDT_LIMIT(8)) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    // First ready port (aempty bit low) scanning from ptr upward, mod 4
    function automatic int model_pick(input logic [3:0] aempty, input int ptr);
        for (int off = 0; off < 4; off++) begin
            int p;
            p = (ptr + off) % 4;
            if (aempty[p] == 1'b0) return p;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.i_fifo_aempty = 4'hF;
        bus.h_fifo_full   = 1'b0;
        bus.b_fifo_afull  = 1'b0;
        bus.frame_done    = 1'b0;
        bus.byte_strobe   = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        arst_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        arst_n = 1'b1;
        ref_ptr = 0;
        exp_abort_cnt = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1;
        checks++;
        if ({bus.grant_valid, bus.grant_start, bus.abort, bus.grant_id, bus.abort_cnt} !== 13'd0)
            begin errors++; $display("FAIL reset_outputs: got v=%b s=%b a=%b id=%0d cnt=%0d expected all 0",
                bus.grant_valid, bus.grant_start, bus.abort, bus.grant_id, bus.abort_cnt); end
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.grant_valid !== 1'b0)
            begin errors++; $display("FAIL reset_no_request: grant_valid=%b expected 0", bus.grant_valid); end
    endtask

    // Serve frames with a fixed request mask; frame_done 4 cycles after grant
    task automatic test_rotation(input logic [3:0] mask, input int nframes, input string tag);
        int exp;
        apply_reset();
        bus.i_fifo_aempty = mask;
        for (int i = 0; i < nframes; i++) begin
            exp = model_pick(mask, ref_ptr);
            @(negedge clk);
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_start !== 1'b1 || bus.grant_id !== exp[1:0])
                begin errors++; $display("FAIL %s_grant[%0d]: v=%b s=%b id=%0d expected v=1 s=1 id=%0d",
                    tag, i, bus.grant_valid, bus.grant_start, bus.grant_id, exp); end
            @(negedge clk);
            checks++;
            if (bus.grant_start !== 1'b0 || bus.grant_valid !== 1'b1)
                begin errors++; $display("FAIL %s_start_width[%0d]: s=%b v=%b expected s=0 v=1",
                    tag, i, bus.grant_start, bus.grant_valid); end
            repeat (3) @(negedge clk);
            bus.frame_done = 1'b1;
            @(negedge clk);
            bus.frame_done = 1'b0;
            checks++;
            if (bus.grant_valid !== 1'b0)
                begin errors++; $display("FAIL %s_gap[%0d]: grant_valid=%b expected 0", tag, i, bus.grant_valid); end
            ref_ptr = (exp + 1) % 4;
            @(negedge clk);
            checks++;
            if (bus.grant_valid !== 1'b0 || bus.grant_start !== 1'b0)
                begin errors++; $display("FAIL %s_idle[%0d]: v=%b s=%b expected 0 0",
                    tag, i, bus.grant_valid, bus.grant_start); end
        end
        bus.i_fifo_aempty = 4'hF;
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.i_fifo_aempty = 4'b0000;
        bus.b_fifo_afull  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.frame_done = (i == 2);
            @(negedge clk);
            checks++;
            if (bus.grant_valid !== 1'b0)
                begin errors++; $display("FAIL bp_body_full[%0d]: grant_valid=%b expected 0", i, bus.grant_valid); end
        end
        bus.frame_done   = 1'b0;
        bus.b_fifo_afull = 1'b0;
        bus.h_fifo_full  = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.grant_valid !== 1'b0)
            begin errors++; $display("FAIL bp_header_full: grant_valid=%b expected 0", bus.grant_valid); end
        bus.h_fifo_full = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.grant_valid !== 1'b1 || bus.grant_start !== 1'b1 || bus.grant_id !== 2'd0)
            begin errors++; $display("FAIL bp_release: v=%b s=%b id=%0d expected 1 1 0",
                bus.grant_valid, bus.grant_start, bus.grant_id); end
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        bus.i_fifo_aempty = 4'hF;
        @(negedge clk);
    endtask

    // Random masks and lengths; flags churn during the hold and must not disturb the grant
    task automatic test_random();
        int exp;
        int len;
        logic [3:0] mask;
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            mask = 4'($urandom_range(0, 14));
            bus.i_fifo_aempty = mask;
            exp = model_pick(mask, ref_ptr);
            @(negedge clk);
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.grant_start !== 1'b1 || bus.grant_id !== exp[1:0])
                begin errors++; $display("FAIL rand_grant[%0d]: v=%b s=%b id=%0d expected 1 1 %0d mask=%b",
                    i, bus.grant_valid, bus.grant_start, bus.grant_id, exp, mask); end
            len = $urandom_range(1, 6);
            for (int c = 0; c < len; c++) begin
                bus.i_fifo_aempty = 4'($urandom);
                bus.h_fifo_full   = 1'($urandom);
                bus.b_fifo_afull  = 1'($urandom);
                bus.byte_strobe   = 1'($urandom);
                @(negedge clk);
                checks++;
                if (bus.grant_valid !== 1'b1 || bus.grant_start !== 1'b0 || bus.grant_id !== exp[1:0])
                    begin errors++; $display("FAIL rand_hold[%0d.%0d]: v=%b s=%b id=%0d expected 1 0 %0d",
                        i, c, bus.grant_valid, bus.grant_start, bus.grant_id, exp); end
            end
            bus.h_fifo_full  = 1'b0;
            bus.b_fifo_afull = 1'b0;
            bus.byte_strobe  = 1'b0;
            bus.frame_done   = 1'b1;
            @(negedge clk);
            bus.frame_done = 1'b0;
            checks++;
            if (bus.grant_valid !== 1'b0)
                begin errors++; $display("FAIL rand_gap[%0d]: grant_valid=%b expected 0", i, bus.grant_valid); end
            ref_ptr = (exp + 1) % 4;
            @(negedge clk);
        end
        bus.i_fifo_aempty = 4'hF;
    endtask

`ifdef RX_ARB_WATCHDOG_EN
    task automatic test_watchdog();
        int exp;
        apply_reset();
        bus.i_fifo_aempty = 4'b0000;
        for (int s = 0; s < 2; s++) begin
            exp = model_pick(4'b0000, ref_ptr);
            @(negedge clk);
            checks++;
            if (bus.grant_start !== 1'b1 || bus.grant_id !== exp[1:0])
                begin errors++; $display("FAIL wdt_grant[%0d]: s=%b id=%0d expected 1 %0d", s, bus.grant_start, bus.grant_id, exp); end
            for (int k = 1; k <= ((s == 0) ? 8 : 14); k++) begin
                @(negedge clk);
                checks++;
                if (bus.grant_valid !== 1'b1 || bus.abort !== 1'b0)
                    begin errors++; $display("FAIL wdt_early[%0d.%0d]: v=%b abort=%b expected 1 0", s, k, bus.grant_valid, bus.abort); end
                bus.byte_strobe = (s == 1) && (k == 5);
            end
            bus.byte_strobe = 1'b0;
            @(negedge clk);
            exp_abort_cnt++;
            checks++;
            if (bus.abort !== 1'b1 || bus.grant_valid !== 1'b0 || bus.abort_cnt !== 8'(exp_abort_cnt))
                begin errors++; $display("FAIL wdt_abort[%0d]: abort=%b v=%b cnt=%0d expected 1 0 %0d",
                    s, bus.abort, bus.grant_valid, bus.abort_cnt, exp_abort_cnt); end
            ref_ptr = (exp + 1) % 4;
            @(negedge clk);
            checks++;
            if (bus.abort !== 1'b0)
                begin errors++; $display("FAIL wdt_abort_width[%0d]: abort=%b expected 0", s, bus.abort); end
        end
    endtask

    task automatic test_done_at_expiry();
        int exp;
        exp = model_pick(4'b0000, ref_ptr);
        @(negedge clk);
        checks++;
        if (bus.grant_start !== 1'b1 || bus.grant_id !== exp[1:0])
            begin errors++; $display("FAIL tie_grant: s=%b id=%0d expected 1 %0d", bus.grant_start, bus.grant_id, exp); end
        repeat (8) @(negedge clk);
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        checks++;
        if (bus.abort !== 1'b0 || bus.grant_valid !== 1'b0 || bus.abort_cnt !== 8'(exp_abort_cnt))
            begin errors++; $display("FAIL tie_release: abort=%b v=%b cnt=%0d expected 0 0 %0d",
                bus.abort, bus.grant_valid, bus.abort_cnt, exp_abort_cnt); end
        ref_ptr = (exp + 1) % 4;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (bus.grant_start !== 1'b1 || bus.grant_id !== 2'((exp + 1) % 4))
            begin errors++; $display("FAIL tie_next_grant: s=%b id=%0d expected 1 %0d",
                bus.grant_start, bus.grant_id, (exp + 1) % 4); end
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        ref_ptr = (ref_ptr + 1) % 4;
        @(negedge clk);
    endtask

    task automatic test_saturation();
        int n;
        for (int s = 0; s < 300; s++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (bus.grant_start !== 1'b1 && n < 6);
            if (bus.grant_start !== 1'b1)
                begin checks++; errors++; $display("FAIL sat_grant_timeout[%0d]: grant_start=%b expected 1", s, bus.grant_start); end
            n = 0;
            do begin @(negedge clk); n++; end while (bus.abort !== 1'b1 && n < 20);
            exp_abort_cnt = (exp_abort_cnt < 255) ? exp_abort_cnt + 1 : 255;
            checks++;
            if (bus.abort !== 1'b1 || n != 9)
                begin errors++; $display("FAIL sat_abort[%0d]: abort=%b after %0d cycles expected 1 after 9", s, bus.abort, n); end
        end
        checks++;
        if (bus.abort_cnt !== 8'(exp_abort_cnt))
            begin errors++; $display("FAIL sat_count: abort_cnt=%0d expected %0d", bus.abort_cnt, exp_abort_cnt); end
        bus.i_fifo_aempty = 4'hF;
    endtask
`else
    task automatic test_no_watchdog();
        apply_reset();
        bus.i_fifo_aempty = 4'b0000;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (bus.grant_valid !== 1'b1 || bus.abort !== 1'b0 || bus.abort_cnt !== 8'd0)
                begin errors++; $display("FAIL nowdt_hold[%0d]: v=%b abort=%b cnt=%0d expected 1 0 0",
                    k, bus.grant_valid, bus.abort, bus.abort_cnt); end
        end
        bus.frame_done = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        bus.i_fifo_aempty = 4'hF;
        @(negedge clk);
    endtask
`endif

    task automatic test_async_reset();
        apply_reset();
        bus.i_fifo_aempty = 4'b1011;
        for (int f = 0; f < 2; f++) begin
            @(negedge clk);
            checks++;
            if (bus.grant_start !== 1'b1 || bus.grant_id !== 2'd2)
                begin errors++; $display("FAIL areset_setup[%0d]: s=%b id=%0d expected 1 2", f, bus.grant_start, bus.grant_id); end
            if (f == 0) begin
                bus.frame_done = 1'b1;
                @(negedge clk);
                bus.frame_done = 1'b0;
                @(negedge clk);
            end
        end
        @(negedge clk);
        #2 arst_n = 1'b0;
        #1;
        checks++;
        if ({bus.grant_valid, bus.grant_start, bus.abort, bus.grant_id, bus.abort_cnt} !== 13'd0)
            begin errors++; $display("FAIL areset_immediate: v=%b s=%b a=%b id=%0d cnt=%0d expected all 0",
                bus.grant_valid, bus.grant_start, bus.abort, bus.grant_id, bus.abort_cnt); end
        bus.i_fifo_aempty = 4'b0000;
        @(negedge clk);
        arst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.grant_start !== 1'b1 || bus.grant_id !== 2'd0)
            begin errors++; $display("FAIL areset_first_grant: s=%b id=%0d expected 1 0", bus.grant_start, bus.grant_id); end
    endtask

    initial begin
        test_reset();
        test_rotation(4'b0000, 5, "rot");
        test_rotation(4'b1010, 4, "mask");
        test_backpressure();
        test_random();
`ifdef RX_ARB_WATCHDOG_EN
        test_watchdog();
        test_done_at_expiry();
        test_saturation();
`else
        test_no_watchdog();
`endif
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
